// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle MIPS-subset core with req/ack instruction and data memories
module multicycle_core #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                NUM_REGS = 32,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [2:0]        state_out,
    output logic              retire,
    output logic              halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam int         IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [5:0] NREGS = 6'(NUM_REGS);

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mdr;
    logic              eq;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op           = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign unused_shamt = ^ir[10:6];

    logic is_r;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic r_legal;
    logic legal;

    assign is_r    = (op == OP_RTYPE);
    assign is_addi = (op == OP_ADDI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);

    always_comb begin
        r_legal = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: r_legal = 1'b1;
            default:                               r_legal = 1'b0;
        endcase
    end

    assign legal = (is_r && r_legal) || is_addi || is_lw || is_sw || is_beq;

    // Size casts of a signed operand sign-extend, which also covers DATA_W == 16.
    logic [DATA_W-1:0] simm;
    logic [ADDR_W-1:0] boff;

    assign simm = DATA_W'($signed(ir[15:0]));
    assign boff = ADDR_W'($signed(ir[15:0])) << 2;

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 5'd0 && {1'b0, rs} < NREGS) rs_val = regs[rs[IDX_W-1:0]];
        if (rt != 5'd0 && {1'b0, rt} < NREGS) rt_val = regs[rt[IDX_W-1:0]];
    end

    logic [DATA_W-1:0] alu_next;

    always_comb begin
        alu_next = a + simm;
        if (is_r) begin
            case (funct)
                FN_SUB:  alu_next = a - b;
                FN_AND:  alu_next = a & b;
                FN_OR:   alu_next = a | b;
                FN_SLT:  alu_next = DATA_W'($signed(a) < $signed(b));
                default: alu_next = a + b;
            endcase
        end else if (is_beq) begin
            alu_next = a - b;
        end
    end

    logic              wr_en;
    logic [4:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ok;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = rd;
        wr_data = alu;
        if (is_r) begin
            wr_en = 1'b1;
        end else if (is_addi) begin
            wr_en  = 1'b1;
            wr_idx = rt;
        end else if (is_lw) begin
            wr_en   = 1'b1;
            wr_idx  = rt;
            wr_data = mdr;
        end
    end

    assign wr_ok = wr_en && (wr_idx != 5'd0) && ({1'b0, wr_idx} < NREGS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            target <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            alu    <= '0;
            mdr    <= '0;
            eq     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a      <= rs_val;
                    b      <= rt_val;
                    target <= pc + ADDR_W'(PC_STEP) + boff;
                    state  <= legal ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    alu <= alu_next;
                    if (is_beq) eq <= (a == b);
                    state <= (is_lw || is_sw) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (is_lw) mdr <= dmem_rdata;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    if (wr_ok) regs[wr_idx[IDX_W-1:0]] <= wr_data;
                    pc    <= (is_beq && eq) ? target : pc + ADDR_W'(PC_STEP);
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Requests are gated by reset so they drop combinationally when reset asserts.
    assign imem_req   = reset && (state == S_FETCH);
    assign imem_addr  = imem_req ? pc : '0;
    assign dmem_req   = reset && (state == S_MEM);
    assign dmem_we    = dmem_req && is_sw;
    assign dmem_addr  = dmem_req ? ADDR_W'(alu) : '0;
    assign dmem_wdata = dmem_we ? b : '0;
    assign pc_out     = pc;
    assign state_out  = state;
    assign retire     = reset && (state == S_WB);
    assign halted     = reset && (state == S_HALT);

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - directed self-checking bench for multicycle_core
module tb_multicycle_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;
    logic [2:0]  state_out;

    logic        s_imem_req, s_imem_ack, s_dmem_req, s_dmem_we, s_dmem_ack, s_retire, s_halted;
    logic [15:0] s_imem_addr, s_dmem_addr, s_dmem_wdata, s_dmem_rdata, s_pc_out;
    logic [31:0] s_imem_rdata;
    logic [2:0]  s_state_out;

    int checks = 0;
    int failures = 0;

    int          imem_wait = 0;
    int          dmem_wait = 0;
    int          icnt = 0;
    int          dcnt = 0;
    int          st_count = 0;
    logic [31:0] mem_addr = 32'hFFFF_FFFF;
    logic [31:0] mem_data = 32'h0;
    logic [31:0] imem [0:63];
    logic [31:0] s_imem [0:15];

    multicycle_core u_dut (
        .clock(clk), .reset(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_out(pc_out), .state_out(state_out), .retire(retire), .halted(halted)
    );

    multicycle_core #(.DATA_W(16), .ADDR_W(16), .NUM_REGS(8)) u_small (
        .clock(clk), .reset(rst_n),
        .imem_req(s_imem_req), .imem_addr(s_imem_addr), .imem_ack(s_imem_ack), .imem_rdata(s_imem_rdata),
        .dmem_req(s_dmem_req), .dmem_we(s_dmem_we), .dmem_addr(s_dmem_addr), .dmem_wdata(s_dmem_wdata),
        .dmem_ack(s_dmem_ack), .dmem_rdata(s_dmem_rdata),
        .pc_out(s_pc_out), .state_out(s_state_out), .retire(s_retire), .halted(s_halted)
    );

    assign imem_ack   = imem_req && (icnt >= imem_wait);
    assign imem_rdata = imem[imem_addr[7:2]];
    assign dmem_ack   = dmem_req && (dcnt >= dmem_wait);
    assign dmem_rdata = (dmem_addr == mem_addr) ? mem_data : 32'h0;

    assign s_imem_ack   = s_imem_req;
    assign s_imem_rdata = s_imem[s_imem_addr[5:2]];
    assign s_dmem_ack   = s_dmem_req;
    assign s_dmem_rdata = 16'h0;

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        if (dmem_req && dmem_we && dmem_ack) begin
            mem_addr <= dmem_addr;
            mem_data <= dmem_wdata;
            st_count <= st_count + 1;
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'hFC00_0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_retires(input int n, input int budget, output bit ok);
        int seen = 0;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (retire) begin
                seen++;
                if (seen == n) begin
                    @(negedge clk);
                    ok = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state_out !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_out); end
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%b exp=0", imem_req); end
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_dmem_req got=%b exp=0", dmem_req); end
        checks++; if (retire !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", retire, halted); end
        checks++; if (imem_addr !== 32'h0 || dmem_we !== 1'b0) begin failures++; $display("FAIL reset_outs got=%h/%b exp=0/0", imem_addr, dmem_we); end
        checks++; if (s_imem_req !== 1'b0 || s_state_out !== 3'd0) begin failures++; $display("FAIL reset_small got=%b/%0d exp=0/0", s_imem_req, s_state_out); end
    endtask

    task automatic test_arith();
        int rc [4];
        int n = 0;
        clear_imem();
        imem[0] = enc_i(8, 0, 1, 5);
        imem[1] = enc_i(8, 0, 2, -3);
        imem[2] = enc_r(1, 2, 3, 32'h20);
        imem[3] = enc_r(2, 1, 4, 32'h2A);
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (retire) begin
                if (n < 4) rc[n] = c;
                n++;
            end
        end
        checks++; if (n != 4) begin failures++; $display("FAIL arith_retire_count got=%0d exp=4", n); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (n > k && rc[k] != 3 + 4 * k) begin failures++; $display("FAIL arith_retire_cycle%0d got=%0d exp=%0d", k, rc[k], 3 + 4 * k); end
        end
        checks++; if (u_dut.regs[2] !== 32'hFFFF_FFFD) begin failures++; $display("FAIL arith_r2 got=%h exp=fffffffd", u_dut.regs[2]); end
        checks++; if (u_dut.regs[3] !== 32'd2) begin failures++; $display("FAIL arith_r3 got=%h exp=2", u_dut.regs[3]); end
        checks++; if (u_dut.regs[4] !== 32'd1) begin failures++; $display("FAIL arith_r4 got=%h exp=1", u_dut.regs[4]); end
        checks++; if (pc_out !== 32'h10) begin failures++; $display("FAIL arith_pc got=%h exp=10", pc_out); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL arith_halted got=%b exp=1", halted); end
    endtask

    task automatic test_alu();
        bit ok;
        clear_imem();
        imem[0] = enc_i(8, 0, 1, 12);
        imem[1] = enc_i(8, 0, 2, 10);
        imem[2] = enc_r(1, 2, 3, 32'h22);
        imem[3] = enc_r(1, 2, 4, 32'h24);
        imem[4] = enc_r(1, 2, 5, 32'h25);
        imem[5] = enc_r(1, 2, 6, 32'h2A);
        do_reset();
        run_retires(6, 60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL alu_timeout got=0 exp=1"); end
        checks++; if (u_dut.regs[3] !== 32'd2) begin failures++; $display("FAIL alu_sub got=%h exp=2", u_dut.regs[3]); end
        checks++; if (u_dut.regs[4] !== 32'd8) begin failures++; $display("FAIL alu_and got=%h exp=8", u_dut.regs[4]); end
        checks++; if (u_dut.regs[5] !== 32'd14) begin failures++; $display("FAIL alu_or got=%h exp=e", u_dut.regs[5]); end
        checks++; if (u_dut.regs[6] !== 32'd0) begin failures++; $display("FAIL alu_slt got=%h exp=0", u_dut.regs[6]); end
    endtask

    task automatic test_mem_stall();
        int rc [3];
        int n = 0;
        int mem_cycles = 0;
        int st_before;
        clear_imem();
        imem[0] = enc_i(8, 0, 1, 5);
        imem[1] = enc_i(32'h2B, 0, 1, 8);
        imem[2] = enc_i(32'h23, 0, 5, 8);
        dmem_wait = 3;
        st_before = st_count;
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (state_out == 3'd3 && dmem_req && dmem_addr == 32'd8) mem_cycles++;
            if (retire) begin
                if (n < 3) rc[n] = c;
                n++;
            end
        end
        dmem_wait = 0;
        checks++; if (n != 3 || rc[1] != 11 || rc[2] != 19) begin failures++; $display("FAIL mem_latency got=%0d/%0d/%0d exp=3/11/19", n, rc[1], rc[2]); end
        checks++; if (mem_cycles != 8) begin failures++; $display("FAIL mem_stall_cycles got=%0d exp=8", mem_cycles); end
        checks++; if (st_count != st_before + 1 || mem_addr !== 32'd8 || mem_data !== 32'd5) begin failures++; $display("FAIL mem_store got=%0d@%h=%h exp=1@8=5", st_count - st_before, mem_addr, mem_data); end
        checks++; if (u_dut.regs[5] !== 32'd5) begin failures++; $display("FAIL mem_load_r5 got=%h exp=5", u_dut.regs[5]); end
    endtask

    task automatic test_imem_stall();
        bit ok;
        int bad = 0;
        clear_imem();
        imem[0] = enc_i(8, 0, 6, 9);
        imem_wait = 2;
        do_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || state_out !== 3'd0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL imem_stall_stable got=%0d exp=0", bad); end
        checks++; if (state_out !== 3'd1) begin failures++; $display("FAIL imem_stall_decode got=%0d exp=1", state_out); end
        run_retires(1, 20, ok);
        imem_wait = 0;
        checks++; if (!ok || u_dut.regs[6] !== 32'd9 || pc_out !== 32'h4) begin failures++; $display("FAIL imem_stall_commit got=%b/%h/%h exp=1/9/4", ok, u_dut.regs[6], pc_out); end
    endtask

    task automatic test_branch();
        bit ok;
        clear_imem();
        imem[0] = enc_i(8, 0, 1, 5);
        imem[1] = enc_i(8, 0, 2, 3);
        imem[2] = enc_i(4, 0, 0, 5);
        imem[8] = enc_i(4, 1, 1, -1);
        do_reset();
        run_retires(3, 40, ok);
        checks++; if (!ok || pc_out !== 32'h20) begin failures++; $display("FAIL branch_fwd got=%b/%h exp=1/20", ok, pc_out); end
        run_retires(2, 20, ok);
        checks++; if (!ok || pc_out !== 32'h20) begin failures++; $display("FAIL branch_self got=%b/%h exp=1/20", ok, pc_out); end
        imem[8] = enc_i(4, 1, 2, 4);
        do_reset();
        run_retires(4, 40, ok);
        checks++; if (!ok || pc_out !== 32'h24) begin failures++; $display("FAIL branch_not_taken got=%b/%h exp=1/24", ok, pc_out); end
    endtask

    task automatic test_r0();
        bit ok;
        clear_imem();
        imem[0] = enc_i(8, 0, 0, 7);
        imem[1] = enc_i(8, 0, 1, 1);
        do_reset();
        run_retires(2, 20, ok);
        checks++; if (!ok || u_dut.regs[1] !== 32'd1) begin failures++; $display("FAIL r0_read got=%b/%h exp=1/1", ok, u_dut.regs[1]); end
        checks++; if (u_dut.regs[0] !== 32'd0) begin failures++; $display("FAIL r0_value got=%h exp=0", u_dut.regs[0]); end
    endtask

    task automatic test_illegal(input logic [31:0] word);
        int bad = 0;
        clear_imem();
        imem[0] = word;
        do_reset();
        @(negedge clk);
        checks++; if (state_out !== 3'd1 || halted !== 1'b0) begin failures++; $display("FAIL illegal_decode got=%0d/%b exp=1/0", state_out, halted); end
        @(negedge clk);
        checks++; if (halted !== 1'b1 || state_out !== 3'd5) begin failures++; $display("FAIL illegal_halt got=%b/%0d exp=1/5", halted, state_out); end
        for (int c = 0; c < 10; c++) begin
            if (imem_req !== 1'b0 || retire !== 1'b0 || dmem_req !== 1'b0 || pc_out !== 32'h0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL illegal_quiet got=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid_mem();
        bit found = 1'b0;
        int st_before;
        clear_imem();
        imem[0] = enc_i(8, 0, 1, 5);
        imem[1] = enc_i(32'h2B, 0, 1, 8);
        dmem_wait = 1000;
        st_before = st_count;
        do_reset();
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (state_out == 3'd3) found = 1'b1;
        end
        checks++; if (!found || dmem_req !== 1'b1) begin failures++; $display("FAIL midmem_reach got=%b/%b exp=1/1", found, dmem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || state_out !== 3'd0) begin failures++; $display("FAIL midmem_drop got=%b/%0d exp=0/0", dmem_req, state_out); end
        repeat (2) @(negedge clk);
        dmem_wait = 0;
        rst_n = 1'b1;
        #1;
        checks++; if (st_count != st_before) begin failures++; $display("FAIL midmem_no_commit got=%0d exp=%0d", st_count, st_before); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || u_dut.regs[1] !== 32'd0) begin failures++; $display("FAIL midmem_restart got=%b/%h/%h exp=1/0/0", imem_req, imem_addr, u_dut.regs[1]); end
    endtask

    task automatic test_small();
        clear_imem();
        do_reset();
        repeat (30) @(negedge clk);
        checks++; if (s_halted !== 1'b1 || s_pc_out !== 16'h10) begin failures++; $display("FAIL small_end got=%b/%h exp=1/10", s_halted, s_pc_out); end
        checks++; if (u_small.regs[1] !== 16'h7FFF) begin failures++; $display("FAIL small_r1 got=%h exp=7fff", u_small.regs[1]); end
        checks++; if (u_small.regs[2] !== 16'h8000) begin failures++; $display("FAIL small_wrap got=%h exp=8000", u_small.regs[2]); end
        checks++; if (u_small.regs[3] !== 16'h0) begin failures++; $display("FAIL small_r9_read got=%h exp=0", u_small.regs[3]); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) s_imem[i] = 32'hFC00_0000;
        s_imem[0] = enc_i(8, 0, 1, 32'h7FFF);
        s_imem[1] = enc_i(8, 1, 2, 1);
        s_imem[2] = enc_i(8, 0, 9, 7);
        s_imem[3] = enc_r(9, 0, 3, 32'h20);
        clear_imem();
        test_reset();
        test_arith();
        test_alu();
        test_mem_stall();
        test_imem_stall();
        test_branch();
        test_r0();
        test_illegal(32'hFC00_0000);
        test_illegal(32'h0000_0021);
        test_reset_mid_mem();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
